// File: rtl/c422_stream_ctrl.sv
// 4:4:4 -> 4:2:2 video stream controller with SOF-gated start/stop and line-length checking.
// Latency: one cycle from input acceptance to output valid (single output register), full throughput.
// Backpressure: s_axis_video_tready = ~m_tvalid | m_tready while forwarding; stalls freeze phase/counter.
//
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   enable                        level run request (start waits for SOF, stop waits for next SOF)
//   line_len[CNT_W-1:0]           expected pixels per line, captured when an SOF beat is forwarded
//   s_axis_video_*                24-bit {V,U,Y} input stream (tuser = SOF, tlast = EOL)
//   m_axis_video_*                16-bit output stream, {U,Y} on even pixels, {V,Y} on odd pixels
//   busy                          high whenever the controller is not IDLE
//   err_short/err_long/err_sof    single-cycle error pulses
//   err_count[ERR_W-1:0]          saturating error total, only when C422_ERR_CNT_EN is defined
//
// Build option: define C422_ERR_CNT_EN to add the err_count port and its counter.

module c422_stream_ctrl #(
  parameter int CNT_W = 12,
  parameter int ERR_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic [CNT_W-1:0] line_len,
  input  logic [23:0]      s_axis_video_tdata,
  input  logic             s_axis_video_tlast,
  input  logic             s_axis_video_tuser,
  input  logic             s_axis_video_tvalid,
  output logic             s_axis_video_tready,
  output logic [15:0]      m_axis_video_tdata,
  output logic             m_axis_video_tlast,
  output logic             m_axis_video_tuser,
  output logic             m_axis_video_tvalid,
  input  logic             m_axis_video_tready,
  output logic             busy,
  output logic             err_short,
  output logic             err_long,
`ifdef C422_ERR_CNT_EN
  output logic             err_sof,
  output logic [ERR_W-1:0] err_count
`else
  output logic             err_sof
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_STOPPING = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             m_vld_q, m_vld_d;
  logic [15:0]      m_dat_q, m_dat_d;
  logic             m_last_q, m_last_d;
  logic             m_user_q, m_user_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic             err_sof_q, err_sof_d;

  logic             s_rdy;
  logic             fwd;        // input beat accepted and loaded into the output register
  logic             out_free;   // output register can take a new beat this cycle
  logic             phase_eff;  // chroma phase of the beat being accepted
  logic [CNT_W-1:0] cnt_inc;    // pixel count of the line including the accepted beat
  logic [CNT_W-1:0] len_eff;    // line length this beat is checked against
  logic [15:0]      map_dat;

  assign out_free = ~m_vld_q | m_axis_video_tready;

  // ---------------------------------------------------------------------------
  // Control FSM: decides readiness and whether an accepted beat is forwarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    s_rdy   = 1'b0;
    fwd     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          // Non-SOF beats are swallowed unconditionally; the SOF beat still
          // needs room in the output register (a leftover beat may be draining).
          s_rdy = s_axis_video_tuser ? out_free : 1'b1;
          if (s_axis_video_tvalid && s_axis_video_tuser && out_free) begin
            fwd     = 1'b1;
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        s_rdy = out_free;
        fwd   = s_axis_video_tvalid & out_free;
        if (!enable) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (enable) begin
          // Re-enable before the frame ended: simply keep streaming.
          s_rdy   = out_free;
          fwd     = s_axis_video_tvalid & out_free;
          state_d = ST_ACTIVE;
        end else if (s_axis_video_tvalid && s_axis_video_tuser) begin
          // Next frame begins: leave it sitting on the input, stop here.
          state_d = ST_IDLE;
        end else begin
          s_rdy = out_free;
          fwd   = s_axis_video_tvalid & out_free;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: an SOF beat always restarts the line at pixel 0 / phase 0.
  // ---------------------------------------------------------------------------
  assign phase_eff = s_axis_video_tuser ? 1'b0 : phase_q;
  assign cnt_inc   = (s_axis_video_tuser ? '0 : cnt_q) + CNT_W'(1);
  assign len_eff   = s_axis_video_tuser ? line_len : len_q;
  assign map_dat   = phase_eff ? {s_axis_video_tdata[23:16], s_axis_video_tdata[7:0]}
                               : s_axis_video_tdata[15:0];

  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    m_vld_d     = m_vld_q;
    m_dat_d     = m_dat_q;
    m_last_d    = m_last_q;
    m_user_d    = m_user_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    err_sof_d   = 1'b0;

    // A stop that ended mid-line must not leave a stale count for the next start.
    if (state_q == ST_IDLE) begin
      phase_d = 1'b0;
      cnt_d   = '0;
    end

    if (out_free) m_vld_d = fwd;

    if (fwd) begin
      m_dat_d  = map_dat;
      m_last_d = s_axis_video_tlast;
      m_user_d = s_axis_video_tuser;
      len_d    = len_eff;
      if (s_axis_video_tlast) begin
        phase_d = 1'b0;
        cnt_d   = '0;
      end else begin
        phase_d = ~phase_eff;
        cnt_d   = cnt_inc;
      end
      err_short_d = s_axis_video_tlast & (cnt_inc < len_eff);
      err_long_d  = s_axis_video_tlast & (cnt_inc > len_eff);
      err_sof_d   = s_axis_video_tuser & (cnt_q != '0);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      m_vld_q     <= 1'b0;
      m_dat_q     <= '0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      m_vld_q     <= m_vld_d;
      m_dat_q     <= m_dat_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_sof_q   <= err_sof_d;
    end
  end

`ifdef C422_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Counts cycles with any error pulse, not individual errors.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((err_short_q || err_long_q || err_sof_q) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

  assign s_axis_video_tready = s_rdy;
  assign m_axis_video_tvalid = m_vld_q;
  assign m_axis_video_tdata  = m_dat_q;
  assign m_axis_video_tlast  = m_last_q;
  assign m_axis_video_tuser  = m_user_q;
  assign busy                = (state_q != ST_IDLE);
  assign err_short           = err_short_q;
  assign err_long            = err_long_q;
  assign err_sof             = err_sof_q;

endmodule

// File: tb/tb_c422_stream_ctrl.sv
// Scoreboard bench for c422_stream_ctrl: directed frames, stalls, stop/start and reset.
module tb_c422_stream_ctrl;
  localparam int CNT_W = 12;
  localparam int ERR_W = 16;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] line_len = '0;
  logic [23:0]      s_tdata = '0;
  logic             s_tlast = 1'b0, s_tuser = 1'b0, s_tvalid = 1'b0;
  logic             s_tready;
  logic [15:0]      m_tdata;
  logic             m_tlast, m_tuser, m_tvalid;
  logic             m_tready = 1'b1;
  logic             busy, err_short, err_long, err_sof;
`ifdef C422_ERR_CNT_EN
  logic [ERR_W-1:0] err_count;
`endif

  c422_stream_ctrl #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .line_len(line_len),
    .s_axis_video_tdata(s_tdata), .s_axis_video_tlast(s_tlast),
    .s_axis_video_tuser(s_tuser), .s_axis_video_tvalid(s_tvalid),
    .s_axis_video_tready(s_tready),
    .m_axis_video_tdata(m_tdata), .m_axis_video_tlast(m_tlast),
    .m_axis_video_tuser(m_tuser), .m_axis_video_tvalid(m_tvalid),
    .m_axis_video_tready(m_tready),
    .busy(busy), .err_short(err_short), .err_long(err_long),
`ifdef C422_ERR_CNT_EN
    .err_sof(err_sof), .err_count(err_count)
`else
    .err_sof(err_sof)
`endif
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output ready: either fixed or random per cycle.
  bit   rnd_mode = 1'b0;
  logic m_tready_fix = 1'b1;
  always @(posedge aclk) begin
    #1;
    m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : m_tready_fix;
  end

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic        u;
    int          c;
  } exp_t;
  exp_t sb[$];
  bit   held = 1'b0;

  // Monitor: compares every presented output beat with the scoreboard head.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out_beat: got tdata 0x%0h with no beat expected (t=%0t)", m_tdata, $time);
      end else begin
        if (!held) check("out_latency_cycle", cyc, sb[0].c);
        check("out_tdata", {16'h0, m_tdata}, {16'h0, sb[0].d});
        check("out_tlast", {31'h0, m_tlast}, {31'h0, sb[0].l});
        check("out_tuser", {31'h0, m_tuser}, {31'h0, sb[0].u});
        if (m_tready) void'(sb.pop_front());
      end
      held = !m_tready;
    end else begin
      held = 1'b0;
    end
  end

  int n_short = 0, n_long = 0, n_sof = 0;
  always @(negedge aclk) begin
    if (aresetn) begin
      if (err_short) n_short++;
      if (err_long)  n_long++;
      if (err_sof)   n_sof++;
    end
  end

  // Present one beat, wait (bounded) for acceptance, push the expected output.
  task automatic send(input logic [23:0] d, input logic lst, input logic usr,
                      input bit fwd, input logic [15:0] exp_d, output int waits);
    bit   acc;
    exp_t e;
    acc      = 1'b0;
    waits    = 0;
    s_tdata  = d;
    s_tlast  = lst;
    s_tuser  = usr;
    s_tvalid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge aclk);
      if (s_tready) begin
        acc = 1'b1;
        break;
      end
      waits++;
    end
    checks++;
    if (!acc) begin
      fails++;
      $display("FAIL send_accept: tready stayed 0 for 300 cycles, data 0x%0h", d);
    end else if (fwd) begin
      e.d = exp_d;
      e.l = lst;
      e.u = usr;
      e.c = cyc + 1;
      sb.push_back(e);
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic tx(input logic [23:0] d, input logic lst, input logic usr, input logic [15:0] exp_d);
    int w;
    send(d, lst, usr, 1'b1, exp_d, w);
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge aclk);
    repeat (2) @(negedge aclk);
    check({nm, "_scoreboard_empty"}, sb.size(), 0);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int          w;
    int          c0;
    logic [23:0] d;
    logic [15:0] e16;

    // Reset state
    #12;
    check("rst_m_tvalid", {31'h0, m_tvalid}, 0);
    check("rst_m_tdata", {16'h0, m_tdata}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_errs", {29'h0, err_short, err_long, err_sof}, 0);
`ifdef C422_ERR_CNT_EN
    check("rst_err_count", {16'h0, err_count}, 0);
`endif
    @(posedge aclk); #1;
    aresetn = 1'b1;
    s_tvalid = 1'b1; s_tuser = 1'b1;
    #2 check("idle_tready_low", {31'h0, s_tready}, 0);
    s_tvalid = 1'b0; s_tuser = 1'b0;
    @(posedge aclk); #1;
    enable = 1'b1; line_len = 12'd4;
    @(posedge aclk); #1;
    check("wait_sof_busy", {31'h0, busy}, 1);

    // Non-SOF beats before the first SOF are swallowed
    for (int i = 0; i < 3; i++) begin
      send(24'h0A0B0C + 24'(i), 1'b0, 1'b0, 1'b0, 16'h0, w);
      check("discard_tready_immediate", w, 0);
    end

    // Two 4-pixel lines at full rate
    c0 = cyc;
    tx(24'h332211, 1'b0, 1'b1, 16'h2211);
    tx(24'h332211, 1'b0, 1'b0, 16'h3311);
    tx(24'h332211, 1'b0, 1'b0, 16'h2211);
    tx(24'h332211, 1'b1, 1'b0, 16'h3311);
    tx(24'h332211, 1'b0, 1'b0, 16'h2211);
    tx(24'h332211, 1'b0, 1'b0, 16'h3311);
    tx(24'h332211, 1'b0, 1'b0, 16'h2211);
    tx(24'h332211, 1'b1, 1'b0, 16'h3311);
    check("full_throughput_cycles", cyc - c0, 8);
    drain("two_lines");
    check("two_lines_errs", n_short + n_long + n_sof, 0);

    // Short line (3) then long line (5)
    tx(24'hC0B0A0, 1'b0, 1'b0, 16'hB0A0);
    tx(24'hC0B0A0, 1'b0, 1'b0, 16'hC0A0);
    tx(24'hC0B0A0, 1'b1, 1'b0, 16'hB0A0);
    check("err_short_pulse", {31'h0, err_short}, 1);
    tx(24'hF1E1D1, 1'b0, 1'b0, 16'hE1D1);
    check("err_short_single_cycle", {31'h0, err_short}, 0);
    tx(24'hF1E1D1, 1'b0, 1'b0, 16'hF1D1);
    tx(24'hF1E1D1, 1'b0, 1'b0, 16'hE1D1);
    tx(24'hF1E1D1, 1'b0, 1'b0, 16'hF1D1);
    tx(24'hF1E1D1, 1'b1, 1'b0, 16'hE1D1);
    check("err_long_pulse", {31'h0, err_long}, 1);
    drain("short_long");
    check("short_count", n_short, 1);
    check("long_count", n_long, 1);
`ifdef C422_ERR_CNT_EN
    check("err_count_2", {16'h0, err_count}, 2);
`endif

    // SOF arriving at pixel 2
    tx(24'h123456, 1'b0, 1'b1, 16'h3456);
    tx(24'h123456, 1'b0, 1'b0, 16'h1256);
    tx(24'h998877, 1'b0, 1'b1, 16'h8877);
    check("err_sof_pulse", {31'h0, err_sof}, 1);
    tx(24'h123456, 1'b0, 1'b0, 16'h1256);
    tx(24'h123456, 1'b0, 1'b0, 16'h3456);
    tx(24'h123456, 1'b1, 1'b0, 16'h1256);
    drain("early_sof");
    check("sof_count", n_sof, 1);
    check("sof_no_len_err", n_short + n_long, 2);
`ifdef C422_ERR_CNT_EN
    check("err_count_3", {16'h0, err_count}, 3);
`endif

    // Stop mid-frame: the rest of the frame is forwarded, next SOF is held off
    tx(24'hABCDEF, 1'b0, 1'b0, 16'hCDEF);
    tx(24'hABCDEF, 1'b0, 1'b0, 16'hABEF);
    enable = 1'b0;
    tx(24'hABCDEF, 1'b0, 1'b0, 16'hCDEF);
    tx(24'hABCDEF, 1'b1, 1'b0, 16'hABEF);
    s_tdata = 24'h111111; s_tuser = 1'b1; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      check("stop_sof_tready_low", {31'h0, s_tready}, 0);
    end
    check("stop_busy_low", {31'h0, busy}, 0);
    @(posedge aclk); #1;
    s_tvalid = 1'b0; s_tuser = 1'b0;
    drain("stop");
    check("stop_errs", n_short + n_long + n_sof, 3);

    // 1920-pixel line with random output stalls
    line_len = 12'd1920;
    enable   = 1'b1;
    rnd_mode = 1'b1;
    @(posedge aclk); #1;
    for (int i = 0; i < 1920; i++) begin
      d   = 24'(i * 24'h010307) ^ 24'h5A5A5A;
      e16 = (i % 2 == 1) ? {d[23:16], d[7:0]} : d[15:0];
      tx(d, (i == 1919), (i == 0), e16);
    end
    drain("long_line");
    check("long_line_errs", n_short + n_long + n_sof, 3);

    // 1-pixel lines (SOF and EOL on the same beat)
    line_len = 12'd1;
    tx(24'h445566, 1'b1, 1'b1, 16'h5566);
    check("one_pix_ok_short", {31'h0, err_short}, 0);
    check("one_pix_ok_long", {31'h0, err_long}, 0);
    line_len = 12'd3;
    tx(24'h778899, 1'b1, 1'b1, 16'h8899);
    check("one_pix_short", {31'h0, err_short}, 1);
    drain("one_pix");
    check("one_pix_short_count", n_short, 2);
    check("one_pix_sof_count", n_sof, 1);
`ifdef C422_ERR_CNT_EN
    check("err_count_4", {16'h0, err_count}, 4);
`endif

    // Reset with a beat stuck in the output register
    rnd_mode     = 1'b0;
    m_tready_fix = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    tx(24'h0F0E0D, 1'b0, 1'b1, 16'h0E0D);
    @(negedge aclk);
    check("pre_reset_m_tvalid", {31'h0, m_tvalid}, 1);
    #2 aresetn = 1'b0;
    #1;
    check("arst_m_tvalid", {31'h0, m_tvalid}, 0);
    check("arst_m_tdata", {16'h0, m_tdata}, 0);
    check("arst_m_flags", {30'h0, m_tlast, m_tuser}, 0);
    check("arst_busy", {31'h0, busy}, 0);
    check("arst_errs", {29'h0, err_short, err_long, err_sof}, 0);
`ifdef C422_ERR_CNT_EN
    check("arst_err_count", {16'h0, err_count}, 0);
`endif
    sb.delete();
    @(posedge aclk); #1;
    aresetn      = 1'b1;
    m_tready_fix = 1'b1;
    line_len     = 12'd2;
    @(posedge aclk); #1;
    send(24'h515253, 1'b0, 1'b0, 1'b0, 16'h0, w);
    tx(24'h616263, 1'b0, 1'b1, 16'h6263);
    tx(24'h717273, 1'b1, 1'b0, 16'h7173);
    drain("post_reset");
    check("final_short", n_short, 2);
    check("final_long", n_long, 1);
    check("final_sof", n_sof, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1);
  end

endmodule
